// File: rtl/xm_latch.sv
// Execute/memory pipeline latch with optional overflow-exception remapping.
// Define XM_EXC_REMAP_EN to turn an overflowing add/addi/sub into a write of
// its exception code to register EXC_REG and to count such exceptions.
// Without the macro the latch is a plain pass-through register stage.
module xm_latch #(
  parameter int unsigned EXC_REG   = 30,
  parameter int unsigned EXC_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          data_aluResult,
  input  logic [31:0]          data_operandB,
  input  logic                 overflow,
  input  logic [1:0]           ctrl_excType,
  input  logic [4:0]           ctrl_writeReg,
  input  logic                 ctrl_regWE,
  input  logic                 ctrl_memWE,
  output logic                 out_valid,
  output logic [31:0]          out_result,
  output logic [31:0]          out_storeData,
  output logic [4:0]           out_writeReg,
  output logic                 out_regWE,
  output logic                 out_memWE,
  output logic                 out_excActive,
  output logic [EXC_CNT_W-1:0] exc_count
);

  localparam logic [4:0] ExcRegIdx = 5'(EXC_REG);

  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic [31:0] store_q, store_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwe_q, regwe_d;
  logic        memwe_q, memwe_d;
  logic        exc_hit;

`ifdef XM_EXC_REMAP_EN
  logic                 exc_q, exc_d;
  logic [EXC_CNT_W-1:0] cnt_q, cnt_d;

  assign exc_hit = in_valid & overflow & (ctrl_excType != 2'd0);

  // Exception flag and saturating exception counter; flushed insns never count
  always_comb begin
    exc_d = exc_q;
    cnt_d = cnt_q;
    if (flush) begin
      exc_d = 1'b0;
    end else if (!stall) begin
      exc_d = exc_hit;
      if (exc_hit && (cnt_q != {EXC_CNT_W{1'b1}})) begin
        cnt_d = cnt_q + EXC_CNT_W'(1);
      end
    end
  end

  // Exception state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      exc_q <= exc_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_excActive = exc_q;
  assign exc_count     = cnt_q;
`else
  // Exception inputs are deliberately ignored in this build
  logic unused_exc;
  assign unused_exc    = ^{overflow, ctrl_excType};
  assign exc_hit       = 1'b0;
  assign out_excActive = 1'b0;
  assign exc_count     = '0;
`endif

  // Next state: flush kills control bits but keeps data, stall holds, else load
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    wreg_d   = wreg_q;
    regwe_d  = regwe_q;
    memwe_d  = memwe_q;
    if (flush) begin
      valid_d = 1'b0;
      regwe_d = 1'b0;
      memwe_d = 1'b0;
    end else if (!stall) begin
      valid_d  = in_valid;
      result_d = data_aluResult;
      store_d  = data_operandB;
      wreg_d   = ctrl_writeReg;
      regwe_d  = ctrl_regWE & in_valid;
      memwe_d  = ctrl_memWE & in_valid;
      if (exc_hit) begin
        // Store data stays as-is; the store itself is suppressed via memWE
        result_d = {30'd0, ctrl_excType};
        wreg_d   = ExcRegIdx;
        regwe_d  = 1'b1;
        memwe_d  = 1'b0;
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      wreg_q   <= '0;
      regwe_q  <= 1'b0;
      memwe_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      wreg_q   <= wreg_d;
      regwe_q  <= regwe_d;
      memwe_q  <= memwe_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_storeData = store_q;
  assign out_writeReg  = wreg_q;
  assign out_regWE     = regwe_q;
  assign out_memWE     = memwe_q;

endmodule

// File: tb/tb_xm_latch.sv
// Scoreboard bench for xm_latch: each driven cycle pushes the expected
// register contents, which are popped and compared after the clock edge.
module tb_xm_latch;

`ifdef XM_EXC_REMAP_EN
  localparam bit Remap = 1'b1;
`else
  localparam bit Remap = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic        regwe;
    logic        memwe;
    logic        exc;
    logic [7:0]  cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] data_aluResult = '0;
  logic [31:0] data_operandB = '0;
  logic        overflow = 1'b0;
  logic [1:0]  ctrl_excType = '0;
  logic [4:0]  ctrl_writeReg = '0;
  logic        ctrl_regWE = 1'b0;
  logic        ctrl_memWE = 1'b0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [31:0] out_storeData;
  logic [4:0]  out_writeReg;
  logic        out_regWE;
  logic        out_memWE;
  logic        out_excActive;
  logic [7:0]  exc_count;

  int n_cmp = 0;
  int n_err = 0;
  exp_t mdl = '0;
  exp_t sb[$];

  xm_latch #(
    .EXC_REG   (30),
    .EXC_CNT_W (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .stall          (stall),
    .flush          (flush),
    .data_aluResult (data_aluResult),
    .data_operandB  (data_operandB),
    .overflow       (overflow),
    .ctrl_excType   (ctrl_excType),
    .ctrl_writeReg  (ctrl_writeReg),
    .ctrl_regWE     (ctrl_regWE),
    .ctrl_memWE     (ctrl_memWE),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_storeData  (out_storeData),
    .out_writeReg   (out_writeReg),
    .out_regWE      (out_regWE),
    .out_memWE      (out_memWE),
    .out_excActive  (out_excActive),
    .exc_count      (exc_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check_eq({tag, ".valid"},  32'(out_valid),     32'(e.valid));
    check_eq({tag, ".result"}, out_result,         e.result);
    check_eq({tag, ".store"},  out_storeData,      e.store);
    check_eq({tag, ".wreg"},   32'(out_writeReg),  32'(e.wreg));
    check_eq({tag, ".regwe"},  32'(out_regWE),     32'(e.regwe));
    check_eq({tag, ".memwe"},  32'(out_memWE),     32'(e.memwe));
    check_eq({tag, ".exc"},    32'(out_excActive), 32'(e.exc));
    check_eq({tag, ".cnt"},    32'(exc_count),     32'(e.cnt));
  endtask

  // Drive one cycle of stimulus at the falling edge, predict, compare after the rising edge
  task automatic cyc(input string tag, input logic v, input logic st, input logic fl,
                     input logic [31:0] alu, input logic [31:0] opb, input logic ov,
                     input logic [1:0] et, input logic [4:0] wr, input logic rwe,
                     input logic mwe);
    bit   hit;
    exp_t e;
    @(negedge clock);
    in_valid = v; stall = st; flush = fl; data_aluResult = alu; data_operandB = opb;
    overflow = ov; ctrl_excType = et; ctrl_writeReg = wr; ctrl_regWE = rwe; ctrl_memWE = mwe;
    hit = Remap && v && ov && (et != 2'd0);
    if (fl) begin
      mdl.valid = 1'b0; mdl.regwe = 1'b0; mdl.memwe = 1'b0; mdl.exc = 1'b0;
    end else if (!st) begin
      mdl.valid = v;
      mdl.store = opb;
      if (hit) begin
        mdl.result = {30'd0, et};
        mdl.wreg   = 5'd30;
        mdl.regwe  = 1'b1;
        mdl.memwe  = 1'b0;
        mdl.exc    = 1'b1;
        if (mdl.cnt != 8'hff) mdl.cnt = mdl.cnt + 8'd1;
      end else begin
        mdl.result = alu;
        mdl.wreg   = wr;
        mdl.regwe  = rwe & v;
        mdl.memwe  = mwe & v;
        mdl.exc    = 1'b0;
      end
    end
    sb.push_back(mdl);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_all(tag, e);
  endtask

  initial begin
    // Reset state, checked between edges while reset is held
    #12;
    check_all("reset", '0);
    reset = 1'b0;

    // Plain add
    cyc("add", 1, 0, 0, 32'h5, 32'h0, 0, 2'd1, 5'd3, 1, 0);
    // Overflowing sub: remapped to exception code, or passed through
    cyc("sub_ovf", 1, 0, 0, 32'h8000_1234, 32'hdead_beef, 1, 2'd3, 5'd7, 1, 0);
    // Overflow flag on a logical op is not an exception
    cyc("logic_ovf", 1, 0, 0, 32'h0f0f_0f0f, 32'h1, 1, 2'd0, 5'd9, 1, 0);
    // Exception on an insn that also stores: store suppressed, data kept
    cyc("exc_store", 1, 0, 0, 32'h7fff_ffff, 32'hcafe_f00d, 1, 2'd1, 5'd4, 0, 1);
    // Invalid insn: bubble even with overflow and WEs set
    cyc("bubble", 0, 0, 0, 32'h1111_2222, 32'h3333_4444, 1, 2'd2, 5'd5, 1, 1);
    // Valid store
    cyc("store", 1, 0, 0, 32'h0000_0100, 32'h0000_abcd, 0, 2'd0, 5'd0, 0, 1);
    // Load something, then stall three cycles with changing inputs
    cyc("pre_stall", 1, 0, 0, 32'h0000_0042, 32'h0000_0077, 0, 2'd0, 5'd12, 1, 0);
    cyc("stall0", 1, 1, 0, 32'h1, 32'h2, 1, 2'd3, 5'd1, 1, 1);
    cyc("stall1", 0, 1, 0, 32'h3, 32'h4, 0, 2'd0, 5'd2, 0, 0);
    cyc("stall2", 1, 1, 0, 32'h5, 32'h6, 1, 2'd2, 5'd3, 1, 0);
    // Flush wins over stall; an exception-raising insn is dropped uncounted
    cyc("flush_stall", 1, 1, 1, 32'h9, 32'ha, 1, 2'd1, 5'd6, 1, 1);
    cyc("after_flush", 1, 0, 0, 32'h0000_0010, 32'h0, 0, 2'd0, 5'd8, 1, 0);

    // 260 back-to-back addi overflows: counter saturates
    for (int i = 0; i < 260; i++) begin
      cyc("addi_ovf", 1, 0, 0, 32'h8000_0000 + 32'(i), 32'(i), 1, 2'd2, 5'(i), 1, 0);
    end
    check_eq("cnt_sat", 32'(exc_count), Remap ? 32'd255 : 32'd0);

    // Valid store captured, then reset pulsed mid-cycle
    cyc("store2", 1, 0, 0, 32'h0000_0200, 32'h0000_5555, 0, 2'd0, 5'd0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_async.memwe", 32'(out_memWE), 32'd0);
    check_eq("rst_async.valid", 32'(out_valid), 32'd0);
    check_eq("rst_async.cnt", 32'(exc_count), 32'd0);
    check_eq("rst_async.result", out_result, 32'd0);
    mdl = '0;
    reset = 1'b0;

    // First edge after reset is a normal load
    cyc("post_reset", 1, 0, 0, 32'h0000_0abc, 32'h0000_0def, 0, 2'd0, 5'd11, 1, 0);
    cyc("post_reset_exc", 1, 0, 0, 32'hffff_0000, 32'h0, 1, 2'd3, 5'd13, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
